// File: rtl/mux_pkg.sv
// Shared constants and types for the 8-channel mux/demux family.
package mux_pkg;

   localparam int unsigned N_CH  = 8;
   localparam int unsigned SEL_W = 3;

   typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_mux_8_1_if.sv
// Bundle of the 8 producer channels and the single registered output stream.
interface rr_mux_8_1_if
   import mux_pkg::*;
#(
   parameter int unsigned DW = 8
);

   logic [N_CH-1:0]    in_valid;
   logic [N_CH*DW-1:0] in_data;
   logic [N_CH-1:0]    in_ready;
   logic               out_valid;
   logic [DW-1:0]      out_data;
   sel_t               out_sel;
   logic               out_ready;

   // master: the mux itself; slave: producers plus consumer around it
   modport master (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      output out_sel,
      input  out_ready
   );

   modport slave (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_sel,
      output out_ready
   );

endinterface

// File: rtl/rr_arbiter_8.sv
// Combinational round-robin arbiter: rotate requests by ptr, pick lowest, rotate back.
module rr_arbiter_8
   import mux_pkg::*;
(
   input  logic [N_CH-1:0] req,
   input  sel_t            ptr,
   output sel_t            grant_idx,
   output logic            any_req
);

   logic [N_CH-1:0] rot;
   sel_t            enc;

   always_comb begin
      rot = '0;
      for (int i = 0; i < N_CH; i++) begin
         rot[i] = req[sel_t'(i) + ptr];
      end
   end

   // Descending scan so the lowest set bit wins.
   always_comb begin
      enc = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (rot[i]) begin
            enc = sel_t'(i);
         end
      end
   end

   assign grant_idx = enc + ptr;
   assign any_req   = |req;

endmodule

// File: rtl/rr_mux_8_1.sv
// Round-robin 8:1 merge of valid/ready channels onto one registered stream tagged with its source.
module rr_mux_8_1
   import mux_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input logic           clk,
   input logic           rst,
   rr_mux_8_1_if.master  bus
);

   sel_t            ptr_q;
   logic            out_valid_q;
   logic [DW-1:0]   out_data_q;
   sel_t            out_sel_q;

   sel_t            grant_idx;
   logic            any_req;
   logic            ld;
   logic [N_CH-1:0] in_ready_d;
   logic [DW-1:0]   ch_data [N_CH];

   rr_arbiter_8 u_arb (
      .req       (bus.in_valid),
      .ptr       (ptr_q),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   // Output stage can take a word when empty or being drained this cycle.
   assign ld = !rst && (!out_valid_q || bus.out_ready);

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         ch_data[i] = bus.in_data[i*DW +: DW];
      end
   end

   always_comb begin
      in_ready_d = '0;
      if (ld && any_req) begin
         in_ready_d[grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else if (ld) begin
         if (any_req) begin
            out_valid_q <= 1'b1;
            out_data_q  <= ch_data[grant_idx];
            out_sel_q   <= grant_idx;
            ptr_q       <= grant_idx + sel_t'(1);
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready_d;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_8_1.sv
// Bench for rr_mux_8_1: directed cycle table followed by randomized traffic against a model.
module tb_rr_mux_8_1;
   import mux_pkg::*;

   localparam int DW = 8;
   localparam int NV = 31;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rr_mux_8_1_if #(.DW(DW)) bus ();

   rr_mux_8_1 #(.DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic       r;
      logic [7:0] v;
      logic       ordy;
      logic [7:0] rdy;
      logic       ov;
      logic [2:0] sel;
      logic       chk_sel;
   } vec_t;

   vec_t tbl [NV];

   function automatic vec_t mk(logic r, logic [7:0] v, logic ordy, logic [7:0] rdy,
                               logic ov, logic [2:0] sel, logic chk_sel);
      vec_t t;
      t.r = r; t.v = v; t.ordy = ordy; t.rdy = rdy; t.ov = ov; t.sel = sel; t.chk_sel = chk_sel;
      return t;
   endfunction

   // Reference model state
   int         m_ptr;
   logic       m_ov;
   logic [7:0] m_data;
   int         m_sel;
   logic [7:0] word [8];

   initial begin
      int n;
      n = 0;
      // Reset held with all channels requesting
      tbl[n++] = mk(1, 8'hFF, 1, 8'h00, 0, 0, 1);
      tbl[n++] = mk(1, 8'hFF, 1, 8'h00, 0, 0, 1);
      // Round robin 0..7,0,1
      for (int k = 0; k < 8; k++) tbl[n++] = mk(0, 8'hFF, 1, 8'(1 << k), 1, 3'(k), 0);
      tbl[n++] = mk(0, 8'hFF, 1, 8'h01, 1, 0, 0);
      tbl[n++] = mk(0, 8'hFF, 1, 8'h02, 1, 1, 0);
      // Stall for 3 cycles, then resume at ptr=2
      for (int k = 0; k < 3; k++) tbl[n++] = mk(0, 8'hFF, 0, 8'h00, 1, 1, 0);
      tbl[n++] = mk(0, 8'hFF, 1, 8'h04, 1, 2, 0);
      for (int k = 3; k < 8; k++) tbl[n++] = mk(0, 8'hFF, 1, 8'(1 << k), 1, 3'(k), 0);
      // Sparse wrap after ch7 served
      tbl[n++] = mk(0, 8'h81, 1, 8'h01, 1, 0, 0);
      tbl[n++] = mk(0, 8'h81, 1, 8'h80, 1, 7, 0);
      tbl[n++] = mk(0, 8'h81, 1, 8'h01, 1, 0, 0);
      // Idle
      tbl[n++] = mk(0, 8'h00, 1, 8'h00, 0, 0, 0);
      tbl[n++] = mk(0, 8'h00, 1, 8'h00, 0, 0, 0);
      // Single requester served back to back
      tbl[n++] = mk(0, 8'h10, 1, 8'h10, 1, 4, 0);
      tbl[n++] = mk(0, 8'h10, 1, 8'h10, 1, 4, 0);
      // Mid-transfer reset, then ptr restarts at 0
      tbl[n++] = mk(0, 8'hFF, 0, 8'h00, 1, 4, 0);
      tbl[n++] = mk(1, 8'hFF, 0, 8'h00, 0, 0, 1);
      tbl[n++] = mk(0, 8'hFF, 1, 8'h01, 1, 0, 0);

      rst = 1'b1;
      bus.in_valid = '0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) bus.in_data[i*DW +: DW] = 8'hA0 + 8'(i);
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         rst = tbl[i].r;
         bus.in_valid = tbl[i].v;
         bus.out_ready = tbl[i].ordy;
         #3;
         check($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
         if (tbl[i].ov || tbl[i].chk_sel)
            check($sformatf("vec%0d out_sel", i), 32'(bus.out_sel), 32'(tbl[i].sel));
         if (tbl[i].ov)
            check($sformatf("vec%0d out_data", i), 32'(bus.out_data), 32'(8'hA0 + 8'(tbl[i].sel)));
      end

      // Randomized traffic against the model
      m_ptr = 0; m_ov = 0; m_data = 0; m_sel = 0;
      for (int c = 0; c < 2000; c++) begin
         logic [7:0] v;
         logic       ordy, ld, found;
         int         g;
         logic [7:0] exp_rdy;
         int         mode;

         rst = (c == 0) || ($urandom_range(0, 99) == 0);
         mode = (c / 150) % 4;
         case (mode)
            0: v = 8'($urandom);
            1: v = 8'($urandom) & 8'($urandom);
            2: v = 8'(1 << $urandom_range(0, 7));
            default: v = 8'hFF;
         endcase
         ordy = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 8; i++) begin
            word[i] = 8'($urandom);
            bus.in_data[i*DW +: DW] = word[i];
         end
         bus.in_valid = v;
         bus.out_ready = ordy;

         ld = !rst && (!m_ov || ordy);
         found = 1'b0;
         g = 0;
         for (int k = 0; k < 8; k++) begin
            if (!found && v[(m_ptr + k) % 8]) begin
               found = 1'b1;
               g = (m_ptr + k) % 8;
            end
         end
         exp_rdy = (ld && found) ? 8'(1 << g) : 8'h00;

         #3;
         check("rand in_ready", 32'(bus.in_ready), 32'(exp_rdy));

         if (rst) begin
            m_ptr = 0; m_ov = 0; m_data = 0; m_sel = 0;
         end else if (ld) begin
            if (found) begin
               m_ov = 1; m_data = word[g]; m_sel = g; m_ptr = (g + 1) % 8;
            end else begin
               m_ov = 0;
            end
         end

         @(posedge clk);
         #1;
         check("rand out_valid", 32'(bus.out_valid), 32'(m_ov));
         if (m_ov) begin
            check("rand out_sel", 32'(bus.out_sel), 32'(m_sel));
            check("rand out_data", 32'(bus.out_data), 32'(m_data));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
